// File: rtl/data_mem_pkg.sv
// Shared access codes, controller states and byte-lane helpers for the
// data-memory controller.
package data_mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
   localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_t;

   // Bit offset of the addressed lane inside the word.
   function automatic logic [4:0] lane_shift(
      input logic       half,
      input logic [1:0] off
   );
      return half ? {off[1], 4'b0000} : {off, 3'b000};
   endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Combinational load alignment: picks the addressed byte/half out of an
// SRAM word and sign- or zero-extends it.
module load_extend
   import data_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  size,
   output logic [31:0] value
);

   logic [31:0] shifted;

   assign shifted = word >> lane_shift(size[0], offset);

   always_comb begin
      value = word;
      unique case (size[1:0])
         2'b00: value = size[2] ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
         2'b01: value = size[2] ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store responder in front of a word-wide SRAM.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t            state;
   logic              we_q;
   logic [2:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              req_err;
   logic [31:0]       ld_val;
   logic [4:0]        sh;
   logic [31:0]       mask;
   logic [31:0]       merged;

   load_extend u_ext (
      .word   (mem_rdata),
      .offset (addr_q[1:0]),
      .size   (size_q),
      .value  (ld_val)
   );

   always_comb begin
      req_err = (req_size == 3'b011) || (req_size[2:1] == 2'b11)
             || (req_we && req_size[2]);
`ifdef MISALIGN_TRAP_EN
      if (req_size[1:0] == 2'b01 && req_addr[0])
         req_err = 1'b1;
      if (req_size == SZ_W && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
`endif
   end

   // Sub-word store: splice the new lane into the word just read.
   always_comb begin
      sh     = lane_shift(size_q[0], addr_q[1:0]);
      mask   = (size_q[0] ? HALF_MASK : BYTE_MASK) << sh;
      merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         mem_en    <= 1'b0;
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  size_q    <= req_size;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end else if (req_we && req_size == SZ_W) begin
                     state     <= WR;
                     mem_en    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= req_addr[ADDR_W-1:2];
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= RD;
                     mem_en   <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= req_addr[ADDR_W-1:2];
                  end
               end
            end
            RD: state <= CAP;
            CAP: begin
               if (!we_q) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ld_val;
               end else begin
                  state     <= WR;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q[ADDR_W-1:2];
                  mem_wdata <= merged;
               end
            end
            WR: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= 32'h0;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_rdata <= 32'h0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: SRAM model, response scoreboard,
// vector table plus back-to-back and mid-access reset sequences.
module tb_data_mem_ctrl;
   import data_mem_pkg::*;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_en;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   logic [31:0] sram [logic [29:0]];
   int cyc = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) begin
            sram[mem_addr] = mem_wdata;
            wr_cnt++;
         end else begin
            mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
            rd_cnt++;
         end
      end
   end

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t q[$];
   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'h1, 32'h0);
         end else begin
            e = q.pop_front();
            chk("rsp_cycle", cyc, e.due);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
         end
      end
   end

   function automatic int lat_of(input logic we, input logic [2:0] sz,
                                 input logic err);
      if (err) return 1;
      if (!we) return 3;
      if (sz == SZ_W) return 2;
      return 4;
   endfunction

   task automatic do_req(input vec_t v, output int acc);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = v.we;
      req_size  = v.size;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'h0, 32'h1);
      acc = cyc;
      q.push_back('{cyc + lat_of(v.we, v.size, v.err), v.rdata, v.err});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("rsp_timeout", q.size(), 32'h0);
         q.delete();
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic err);
      vec_t v;
      v.we = we; v.size = sz; v.addr = a;
      v.wdata = wd; v.rdata = rd; v.err = err;
      return v;
   endfunction

   initial begin
      int acc1, acc2, w0, r0;
      vec_t v;
      logic [31:0] w20;

      sram[30'h4] = 32'h8899_AABB;
      repeat (3) @(negedge clk);
      chk("rst_outs", {27'h0, req_ready, rsp_valid, rsp_err, mem_en, mem_we},
          32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_maddr", {2'b00, mem_addr}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      #1 chk("ready_pre_edge", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk("ready_post_rst", {31'h0, req_ready}, 32'h1);

      // Word store followed at once by a load of the same word.
      w0 = wr_cnt; r0 = rd_cnt;
      do_req(mk(1, SZ_W, 32'h20, 32'h1234_5678, 0, 0), acc1);
      do_req(mk(0, SZ_W, 32'h20, 0, 32'h1234_5678, 0), acc2);
      wait_done();
      chk("b2b_accept", acc2, acc1 + 3);
      chk("b2b_wr", wr_cnt - w0, 1);
      chk("b2b_rd", rd_cnt - r0, 1);

      w20 = TRAP ? 32'h1234_5678 : 32'hCAFE_F00D;
      vecs.push_back(mk(0, SZ_B,  32'h11, 0, 32'hFFFF_FFAA, 0));
      vecs.push_back(mk(0, SZ_BU, 32'h11, 0, 32'h0000_00AA, 0));
      vecs.push_back(mk(0, SZ_H,  32'h12, 0, 32'hFFFF_8899, 0));
      vecs.push_back(mk(0, SZ_HU, 32'h12, 0, 32'h0000_8899, 0));
      vecs.push_back(mk(0, SZ_W,  32'h10, 0, 32'h8899_AABB, 0));
      vecs.push_back(mk(0, SZ_B,  32'h10, 0, 32'hFFFF_FFBB, 0));
      vecs.push_back(mk(1, SZ_B,  32'h13, 32'hFFFF_FF5C, 0, 0));
      vecs.push_back(mk(0, SZ_W,  32'h10, 0, 32'h5C99_AABB, 0));
      vecs.push_back(mk(1, SZ_H,  32'h10, 32'h1234_BEEF, 0, 0));
      vecs.push_back(mk(0, SZ_W,  32'h10, 0, 32'h5C99_BEEF, 0));
      vecs.push_back(mk(0, SZ_H,  32'h10, 0, 32'hFFFF_BEEF, 0));
      vecs.push_back(mk(1, SZ_BU, 32'h10, 32'h0, 0, 1));
      vecs.push_back(mk(0, 3'b011, 32'h10, 0, 0, 1));
      vecs.push_back(mk(0, 3'b111, 32'h10, 0, 0, 1));
      vecs.push_back(mk(1, SZ_HU, 32'h10, 32'h0, 0, 1));
      vecs.push_back(mk(0, 3'b110, 32'h10, 0, 0, 1));
      vecs.push_back(mk(0, SZ_W,  32'h10, 0, 32'h5C99_BEEF, 0));
      vecs.push_back(mk(0, SZ_W,  32'h22, 0,
                        TRAP ? 32'h0 : 32'h1234_5678, TRAP));
      vecs.push_back(mk(0, SZ_H,  32'h13, 0,
                        TRAP ? 32'h0 : 32'h0000_5C99, TRAP));
      vecs.push_back(mk(0, SZ_HU, 32'h11, 0,
                        TRAP ? 32'h0 : 32'h0000_BEEF, TRAP));
      vecs.push_back(mk(1, SZ_W,  32'h21, 32'hCAFE_F00D, 0, TRAP));
      vecs.push_back(mk(0, SZ_W,  32'h20, 0, w20, 0));
      vecs.push_back(mk(0, SZ_BU, 32'h23, 0, {24'h0, w20[31:24]}, 0));
      vecs.push_back(mk(1, SZ_B,  32'h22, 32'h0000_00A5, 0, 0));
      vecs.push_back(mk(0, SZ_W,  32'h20, 0,
                        {w20[31:24], 8'hA5, w20[15:0]}, 0));

      foreach (vecs[i]) begin
         v = vecs[i];
         w0 = wr_cnt; r0 = rd_cnt;
         do_req(v, acc1);
         wait_done();
         chk($sformatf("v%0d_wr", i), wr_cnt - w0,
             (!v.err && v.we) ? 1 : 0);
         chk($sformatf("v%0d_rd", i), rd_cnt - r0,
             (!v.err && !(v.we && v.size == SZ_W)) ? 1 : 0);
      end

      // Reset during CAP of a sub-word store must abort without writing.
      @(negedge clk);
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B;
      req_addr = 32'h21; req_wdata = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {27'h0, req_ready, rsp_valid, rsp_err, mem_en, mem_we},
          32'h0);
      chk("abort_maddr", {2'b00, mem_addr}, 32'h0);
      chk("abort_wdata", mem_wdata, 32'h0);
      chk("abort_rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_wr", wr_cnt - w0, 0);
      chk("abort_ready", {31'h0, req_ready}, 32'h1);
      do_req(mk(0, SZ_W, 32'h20, 0, {w20[31:24], 8'hA5, w20[15:0]}, 0), acc1);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory responder that executes the load/store requests whose type the control decoder encodes on DataSrc (loads) and funct3 (stores). It sits between the core's memory stage and a word-wide synchronous SRAM that has no byte enables. It performs byte, halfword and word accesses, does read-modify-write for sub-word stores, and sign- or zero-extends load data.

## Interface
Parameters:
- ADDR_W, 32: byte-address width; memory word address is ADDR_W-2 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  access code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (the last two are loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; qualified by rsp_valid.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write.
- mem_addr  out  ADDR_W-2  SRAM word address.
- mem_wdata  out  32  SRAM write word.
- mem_rdata  in  32  SRAM read word, valid one cycle after a read strobe.

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the block latches we, size, addr and wdata.
  - Next state depends on the request:
    - load → RD
    - word store → WR
    - sub-word store → RD
    - error → RESP
- RD: mem_en=1, mem_we=0, mem_addr=addr[ADDR_W-1:2]. Next state is CAP.
- CAP: latch mem_rdata.
  - Load: extract and extend the data, then go to RESP.
  - Sub-word store: merge the data, then go to WR.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Codes 000/001 sign-extend; codes 100/101 zero-extend.
- Store merge: replace byte lane addr[1:0] with wdata[7:0], or half lane addr[1] with wdata[15:0]. All other bytes are preserved.
- WR: mem_en=1, mem_we=1, mem_wdata = merged word (or wdata for a word store). Next state is RESP.
- RESP: rsp_valid=1, then return to IDLE.
- Errors, always checked:
  - Code 011, 110 or 111.
  - A store with a code of 1xx.
- Error handling: no memory access; rsp_err=1, rsp_rdata=0.
- mem_en=0 in every state other than RD and WR. mem_wdata, mem_addr and mem_we hold their last value.

## Timing
- Reset (asynchronous, rst_n low):
  - state=IDLE; all outputs 0, including req_ready.
  - req_ready rises on the first clk edge with rst_n high.
- Latency from the acceptance edge T to rsp_valid:

| Request | rsp_valid high in cycle |
|---|---|
| Load | T+3 |
| Word store | T+2 |
| Sub-word store | T+4 |
| Error | T+1 |

- req_ready is low from the cycle after T until the cycle after RESP.
- Back-to-back: a new request can be accepted in the cycle following RESP. There is no overlap with RESP.
- There is no rsp_ready: the core must sample the rsp_valid pulse.
- req_valid while req_ready=0 is ignored; the request is not queued.
- Reset asserted mid-access aborts immediately. An SRAM write is issued only in WR, so an abort before WR leaves memory untouched.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Half accesses with addr[0]=1 are errors.
  - Word accesses with addr[1:0]≠0 are errors.
  - Both take the single-cycle error path.
- Undefined:
  - Misaligned low bits are ignored: half uses addr[1] only, word ignores addr[1:0].
  - No alignment error is raised. Code errors still apply.

## Structure
- Package data_mem_pkg holds:
  - the access-code localparams (SZ_B=000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101)
  - the state enum
  - the byte-lane helper constants
- Sub-module load_extend: purely combinational (word, addr[1:0], size) → extended 32-bit load value. It is instantiated once in CAP.

## Test plan
- Preload word 0x8899AABB at 0x10. lb from 0x11 → rsp_rdata 0xFFFFFFAA at T+3. lbu from 0x11 → 0x000000AA.
- lh from 0x12 → 0xFFFF8899; lhu from 0x12 → 0x00008899; lw from 0x10 → 0x8899AABB.
- sb 0x5C to 0x13 over 0x8899AABB → memory holds 0x5C99AABB; rsp_valid at T+4. Only one mem_we pulse, in WR.
- sw 0x12345678 to 0x20 → rsp_valid at T+2 with no RD cycle. A following lw from 0x20 → 0x12345678. The back-to-back request is accepted the cycle after RESP.
- lw from 0x22:
  - MISALIGN_TRAP_EN defined: rsp_err=1 at T+1, mem_en never high.
  - Undefined: returns the word at 0x20.
- Store with code 100 → rsp_err=1, memory unchanged. Drop rst_n during CAP of a sub-word store → outputs 0 at once, no write, req_ready=1 after release.
